// File: rtl/dma_pcie_h2c_byp_pkg.sv
// Shared types for the H2C descriptor bypass-in sink: descriptor struct, output FSM states
// and a round-robin pick helper used by both the credit and the output arbiters.
`ifndef QID_WIDTH
`define QID_WIDTH 11
`endif

package dma_pcie_h2c_byp_pkg;

  localparam int unsigned H2C_BYP_NCHN_MAX = 4;
  localparam int unsigned QID_W            = `QID_WIDTH;

  typedef struct packed {
    logic [63:0]      dsc;
    logic [QID_W-1:0] qid;
    logic             wbi;
    logic             wbi_chk;
    logic [15:0]      cidx;
    logic [15:0]      len;
    logic             last;
    logic [1:0]       chn;
  } h2c_byp_dsc_t;

  typedef enum logic [0:0] {
    StIdle,
    StLock
  } h2c_byp_out_st_e;

  // Returns {found, index}: first set request at or after start, wrapping.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int i = H2C_BYP_NCHN_MAX - 1; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/dma_pcie_h2c_byp_fifo.sv
// Synchronous show-ahead FIFO of bypass descriptors; pushes into a full FIFO are dropped.
module dma_pcie_h2c_byp_fifo
  import dma_pcie_h2c_byp_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  h2c_byp_dsc_t             din_i,
  input  logic                     pop_i,
  output h2c_byp_dsc_t             dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  h2c_byp_dsc_t     mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/dma_pcie_h2c_byp_in_sink.sv
// Credit-issuing sink of the H2C bypass-in interface: per-channel FIFOs, credit return and
// packet-atomic round-robin forwarding. Optional credit check: DMA_H2C_BYP_IN_CRDT_CHK_EN.
module dma_pcie_h2c_byp_in_sink
  import dma_pcie_h2c_byp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NCHN  = 4
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic [63:0]           byp_in_dsc,
  input  logic [`QID_WIDTH-1:0] byp_in_qid,
  input  logic                  byp_in_wbi,
  input  logic                  byp_in_wbi_chk,
  input  logic [15:0]           byp_in_cidx,
  input  logic [15:0]           byp_in_len,
  input  logic                  byp_in_last,
  input  logic [1:0]            byp_in_chn,
  input  logic                  byp_in_vld,
  output logic                  byp_in_crdt,
  output logic [1:0]            byp_in_crdt_chn,
  output logic [63:0]           out_dsc,
  output logic [`QID_WIDTH-1:0] out_qid,
  output logic                  out_wbi,
  output logic                  out_wbi_chk,
  output logic [15:0]           out_cidx,
  output logic [15:0]           out_len,
  output logic                  out_last,
  output logic [1:0]            out_chn,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  err_no_crdt
);

  localparam int unsigned ChnMax = H2C_BYP_NCHN_MAX;
  localparam int unsigned PendW  = $clog2(DEPTH) + 1;
  localparam logic [ChnMax-1:0] ChnEn = ChnMax'((1 << NCHN) - 1);

  h2c_byp_dsc_t      in_dsc;
  h2c_byp_dsc_t      fifo_dout [ChnMax];
  logic [PendW-1:0]  fifo_cnt [ChnMax];
  logic [PendW-1:0]  pend_q [ChnMax];
  logic [ChnMax-1:0] chn_hit, push, pop, empty, full, req, pend_nz, issue;
  logic [2:0]        crdt_pick, out_pick;
  logic [1:0]        crdt_ptr_q, out_ptr_q, out_ptr_d, lock_q, lock_d;
  logic              crdt_q;
  logic [1:0]        crdt_chn_q;

  h2c_byp_out_st_e   st_q, st_d;
  h2c_byp_dsc_t      out_q, out_d;
  logic              out_vld_q, out_vld_d;

  assign in_dsc = '{dsc: byp_in_dsc, qid: byp_in_qid, wbi: byp_in_wbi, wbi_chk: byp_in_wbi_chk,
                    cidx: byp_in_cidx, len: byp_in_len, last: byp_in_last, chn: byp_in_chn};

  for (genvar c = 0; c < ChnMax; c++) begin : g_chn
    assign chn_hit[c] = byp_in_vld && (byp_in_chn == 2'(c)) && ChnEn[c];
    assign req[c]     = (fifo_cnt[c] != '0);
    assign pend_nz[c] = (pend_q[c] != '0);
    assign issue[c]   = crdt_pick[2] && (crdt_pick[1:0] == 2'(c));
    if (c < NCHN) begin : g_fifo
      dma_pcie_h2c_byp_fifo #(
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk_i   (axi_aclk),
        .rst_ni  (axi_aresetn),
        .push_i  (push[c]),
        .din_i   (in_dsc),
        .pop_i   (pop[c]),
        .dout_o  (fifo_dout[c]),
        .empty_o (empty[c]),
        .full_o  (full[c]),
        .count_o (fifo_cnt[c])
      );
    end else begin : g_unused
      assign empty[c]     = 1'b1;
      assign full[c]      = 1'b0;
      assign fifo_dout[c] = '0;
      assign fifo_cnt[c]  = '0;
    end
  end

`ifdef DMA_H2C_BYP_IN_CRDT_CHK_EN
  logic [PendW-1:0]  outst_q [ChnMax];
  logic [ChnMax-1:0] outst_nz;
  logic              err_q;

  for (genvar c = 0; c < ChnMax; c++) begin : g_outst
    assign outst_nz[c] = (outst_q[c] != '0);
    assign push[c]     = chn_hit[c] && !full[c] && outst_nz[c];
  end

  // A beat without an outstanding credit is dropped and latches the error until reset.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      err_q <= 1'b0;
      for (int c = 0; c < ChnMax; c++) outst_q[c] <= '0;
    end else begin
      if (|(chn_hit & ~outst_nz)) err_q <= 1'b1;
      for (int c = 0; c < ChnMax; c++) begin
        outst_q[c] <= outst_q[c] + PendW'(issue[c]) - PendW'(push[c]);
      end
    end
  end

  assign err_no_crdt = err_q;

  for (genvar c = 0; c < NCHN; c++) begin : g_inv
    a_crdt_inv: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
      (32'(pend_q[c]) + 32'(outst_q[c]) + 32'(fifo_cnt[c]) == DEPTH));
  end
`else
  assign push        = chn_hit & ~full;
  assign err_no_crdt = 1'b0;
`endif

  // Credit return: one registered pulse per cycle, round-robin over channels owed credits.
  assign crdt_pick = rr_pick(pend_nz, crdt_ptr_q);

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      crdt_q     <= 1'b0;
      crdt_chn_q <= '0;
      crdt_ptr_q <= '0;
      for (int c = 0; c < ChnMax; c++) pend_q[c] <= ChnEn[c] ? PendW'(DEPTH) : '0;
    end else begin
      crdt_q <= crdt_pick[2];
      if (crdt_pick[2]) begin
        crdt_chn_q <= crdt_pick[1:0];
        crdt_ptr_q <= crdt_pick[1:0] + 2'd1;
      end
      for (int c = 0; c < ChnMax; c++) begin
        pend_q[c] <= pend_q[c] + PendW'(pop[c]) - PendW'(issue[c]);
      end
    end
  end

  assign byp_in_crdt     = crdt_q;
  assign byp_in_crdt_chn = crdt_chn_q;

  assign out_pick = rr_pick(req, out_ptr_q);

  always_comb begin
    st_d      = st_q;
    lock_d    = lock_q;
    out_ptr_d = out_ptr_q;
    out_d     = out_q;
    out_vld_d = out_vld_q && !out_rdy;
    pop       = '0;
    unique case (st_q)
      StIdle: begin
        if (out_pick[2]) begin
          st_d      = StLock;
          lock_d    = out_pick[1:0];
          out_ptr_d = out_pick[1:0] + 2'd1;
        end
      end
      StLock: begin
        // Stay locked to the channel until its last beat, waiting if it runs dry.
        if (!empty[lock_q] && (!out_vld_q || out_rdy)) begin
          pop[lock_q] = 1'b1;
          out_d       = fifo_dout[lock_q];
          out_vld_d   = 1'b1;
          if (fifo_dout[lock_q].last) st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      st_q      <= StIdle;
      lock_q    <= '0;
      out_ptr_q <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      lock_q    <= lock_d;
      out_ptr_q <= out_ptr_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign out_dsc     = out_q.dsc;
  assign out_qid     = out_q.qid;
  assign out_wbi     = out_q.wbi;
  assign out_wbi_chk = out_q.wbi_chk;
  assign out_cidx    = out_q.cidx;
  assign out_len     = out_q.len;
  assign out_last    = out_q.last;
  assign out_chn     = out_q.chn;
  assign out_vld     = out_vld_q;

endmodule

// File: tb/tb_dma_pcie_h2c_byp_in_sink.sv
// Scoreboard bench for dma_pcie_h2c_byp_in_sink: stimulus queues expected beats and credits,
// a negedge monitor compares everything the DUT presents.
`ifndef QID_WIDTH
`define QID_WIDTH 11
`endif

module tb_dma_pcie_h2c_byp_in_sink;
  import dma_pcie_h2c_byp_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned NCHN  = 4;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [63:0]           byp_in_dsc;
  logic [`QID_WIDTH-1:0] byp_in_qid;
  logic                  byp_in_wbi, byp_in_wbi_chk, byp_in_last, byp_in_vld;
  logic [15:0]           byp_in_cidx, byp_in_len;
  logic [1:0]            byp_in_chn;
  logic                  crdt;
  logic [1:0]            crdt_chn;
  logic [63:0]           out_dsc;
  logic [`QID_WIDTH-1:0] out_qid;
  logic                  out_wbi, out_wbi_chk, out_last, out_vld, out_rdy, err;
  logic [15:0]           out_cidx, out_len;
  logic [1:0]            out_chn;

  always #5 clk = ~clk;

  dma_pcie_h2c_byp_in_sink #(
    .DEPTH (DEPTH),
    .NCHN  (NCHN)
  ) dut (
    .axi_aclk        (clk),
    .axi_aresetn     (rstn),
    .byp_in_dsc      (byp_in_dsc),
    .byp_in_qid      (byp_in_qid),
    .byp_in_wbi      (byp_in_wbi),
    .byp_in_wbi_chk  (byp_in_wbi_chk),
    .byp_in_cidx     (byp_in_cidx),
    .byp_in_len      (byp_in_len),
    .byp_in_last     (byp_in_last),
    .byp_in_chn      (byp_in_chn),
    .byp_in_vld      (byp_in_vld),
    .byp_in_crdt     (crdt),
    .byp_in_crdt_chn (crdt_chn),
    .out_dsc         (out_dsc),
    .out_qid         (out_qid),
    .out_wbi         (out_wbi),
    .out_wbi_chk     (out_wbi_chk),
    .out_cidx        (out_cidx),
    .out_len         (out_len),
    .out_last        (out_last),
    .out_chn         (out_chn),
    .out_vld         (out_vld),
    .out_rdy         (out_rdy),
    .err_no_crdt     (err)
  );

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  h2c_byp_dsc_t exp_out[$];
  int           exp_crdt[$];
  int           crdt_cnt[4];
  int           out_cnt = 0;
  int           first_out_cyc = 0;
  int           last_out_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic h2c_byp_dsc_t mk(input logic [1:0] chn, input logic [15:0] len,
                                      input logic last, input logic [63:0] dsc);
    h2c_byp_dsc_t d;
    d.dsc     = dsc;
    d.qid     = QID_W'(dsc ^ 64'h5a5);
    d.wbi     = dsc[0];
    d.wbi_chk = dsc[1];
    d.cidx    = dsc[31:16];
    d.len     = len;
    d.last    = last;
    d.chn     = chn;
    return d;
  endfunction

  // Drives one beat for one cycle; returns at posedge+1.
  task automatic send(input h2c_byp_dsc_t d);
    byp_in_dsc     = d.dsc;
    byp_in_qid     = d.qid;
    byp_in_wbi     = d.wbi;
    byp_in_wbi_chk = d.wbi_chk;
    byp_in_cidx    = d.cidx;
    byp_in_len     = d.len;
    byp_in_last    = d.last;
    byp_in_chn     = d.chn;
    byp_in_vld     = 1'b1;
    @(posedge clk); #1;
    byp_in_vld     = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_crdt();
    for (int i = 0; i < 4; i++) crdt_cnt[i] = 0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_out.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    chk("drain_remaining", exp_out.size(), 0);
  endtask

  // Monitor: output beats, output stability under back-pressure, credit pulses.
  initial begin
    h2c_byp_dsc_t act, prev;
    bit           hold;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      act = '{dsc: out_dsc, qid: out_qid, wbi: out_wbi, wbi_chk: out_wbi_chk, cidx: out_cidx,
              len: out_len, last: out_last, chn: out_chn};
      if (rstn) begin
        if (hold) chk("out_stable", act, prev);
        if (out_vld && out_rdy) begin
          if (exp_out.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_unexpected actual=%0h required=no_beat", act);
          end else begin
            chk("out_beat", act, exp_out.pop_front());
          end
          if (out_cnt == 0) first_out_cyc = cyc;
          last_out_cyc = cyc;
          out_cnt++;
        end
        hold = out_vld && !out_rdy;
        prev = act;
        if (crdt) begin
          if (exp_crdt.size() != 0) chk("crdt_seq_chn", crdt_chn, exp_crdt.pop_front());
          crdt_cnt[crdt_chn]++;
        end else if (exp_crdt.size() != 0 && exp_crdt.size() < 32) begin
          checks++;
          failures++;
          $display("FAIL crdt_gap actual=0 required=1 remaining=%0d", exp_crdt.size());
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic reset_and_burst();
    rstn = 1'b0;
    step(3);
    @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_crdt", crdt, 0);
    chk("rst_crdt_chn", crdt_chn, 0);
    chk("rst_out_data", {out_dsc, out_len, out_chn, out_last}, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    exp_out.delete();
    exp_crdt.delete();
    for (int i = 0; i < 32; i++) exp_crdt.push_back(i % 4);
    clear_crdt();
    rstn = 1'b1;
    step(40);
    chk("crdt_init_done", exp_crdt.size(), 0);
    chk("crdt_init_total", crdt_cnt[0] + crdt_cnt[1] + crdt_cnt[2] + crdt_cnt[3], 32);
    chk("crdt_init_chn3", crdt_cnt[3], 8);
    chk("post_rst_out_vld", out_vld, 0);
  endtask

  initial begin
    h2c_byp_dsc_t d;
    int           w;
    int           n;
    rstn       = 1'b0;
    out_rdy    = 1'b0;
    byp_in_vld = 1'b0;
    d          = mk(2'd0, 16'd0, 1'b0, 64'd0);
    send(d);
    byp_in_vld = 1'b0;

    // Initial credit burst.
    reset_and_burst();
    step(5);
    chk("crdt_quiet_total", crdt_cnt[0] + crdt_cnt[1] + crdt_cnt[2] + crdt_cnt[3], 32);

    // 3-beat packet on chn 2, minimum latency.
    out_rdy = 1'b1;
    clear_crdt();
    out_cnt = 0;
    w = cyc + 1;
    d = mk(2'd2, 16'd64, 1'b0, 64'hA000_0000_1111_0001); exp_out.push_back(d); send(d);
    d = mk(2'd2, 16'd64, 1'b0, 64'hA000_0000_2222_0002); exp_out.push_back(d); send(d);
    d = mk(2'd2, 16'd32, 1'b1, 64'hA000_0000_3333_0003); exp_out.push_back(d); send(d);
    n = 0;
    while (out_cnt < 3 && n < 20) begin step(1); n++; end
    chk("p3_beats_out", out_cnt, 3);
    chk("p3_first_lat", first_out_cyc - w, 2);
    chk("p3_last_lat", last_out_cyc - w, 4);
    step(NCHN + 2);
    chk("p3_crdt_chn2", crdt_cnt[2], 3);
    chk("p3_crdt_other", crdt_cnt[0] + crdt_cnt[1] + crdt_cnt[3], 0);

    // Interleaved 2-beat packets on chn 0 and chn 1: packet-atomic output order.
    clear_crdt();
    begin
      h2c_byp_dsc_t a0, a1, b0, b1;
      a0 = mk(2'd0, 16'd16, 1'b0, 64'hB000_0000_0000_0A00);
      b0 = mk(2'd1, 16'd17, 1'b0, 64'hB000_0000_0000_0B00);
      a1 = mk(2'd0, 16'd18, 1'b1, 64'hB000_0000_0000_0A01);
      b1 = mk(2'd1, 16'd19, 1'b1, 64'hB000_0000_0000_0B01);
      exp_out.push_back(a0);
      exp_out.push_back(a1);
      exp_out.push_back(b0);
      exp_out.push_back(b1);
      send(a0);
      send(b0);
      send(a1);
      send(b1);
    end
    wait_drain(30);
    step(NCHN + 4);
    chk("il_crdt_chn0", crdt_cnt[0], 2);
    chk("il_crdt_chn1", crdt_cnt[1], 2);

    // Back-pressure: 8 beats on chn 3 with out_rdy low for 20 cycles.
    out_rdy = 1'b0;
    clear_crdt();
    for (int i = 0; i < 8; i++) begin
      d = mk(2'd3, 16'(100 + i), (i == 7), 64'hC000_0000_0000_0000 | 64'(i * 4 + 3));
      exp_out.push_back(d);
      send(d);
    end
    step(12);
    chk("bp_out_vld", out_vld, 1);
    chk("bp_out_head", out_dsc, 64'hC000_0000_0000_0003);
    // Only the head beat has left FIFO[3] (into the output register).
    chk("bp_crdt_chn3", crdt_cnt[3], 1);
    out_rdy = 1'b1;
    wait_drain(30);
    step(NCHN + 10);
    chk("bp_crdt_drain", crdt_cnt[3], 8);

`ifdef DMA_H2C_BYP_IN_CRDT_CHK_EN
    // Beat with no outstanding credit on chn 1.
    out_rdy = 1'b0;
    d = mk(2'd1, 16'd1, 1'b0, 64'hD000_0000_0000_0100);
    exp_out.push_back(d);
    send(d);
    step(6);
    for (int i = 1; i <= 8; i++) begin
      d = mk(2'd1, 16'(i + 1), (i == 8), 64'hD000_0000_0000_0100 | 64'(i));
      exp_out.push_back(d);
      send(d);
    end
    chk("chk_err_before", err, 0);
    d = mk(2'd1, 16'd99, 1'b1, 64'hDEAD_0000_0000_0199);
    send(d);
    chk("chk_err_set", err, 1);
    out_rdy = 1'b1;
    wait_drain(40);
    step(5);
    chk("chk_err_sticky", err, 1);
`else
    chk("err_tied_low", err, 0);
`endif

    // Reset while chn 0 holds buffered beats.
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = mk(2'd0, 16'(200 + i), (i == 4), 64'hE000_0000_0000_0000 | 64'(i));
      send(d);
    end
    step(2);
    chk("mid_out_vld", out_vld, 1);
    out_rdy = 1'b1;
    reset_and_burst();
    step(10);
    chk("mid_no_output", out_cnt, 3 + 4 + 8
`ifdef DMA_H2C_BYP_IN_CRDT_CHK_EN
      + 9
`endif
    );

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
